// File: rtl/rr_grant_stage.sv
// rr_grant_stage
//   Downstream stage of the round-robin arbiter rr_top. Takes the arbiter's
//   selected index, captures that requester's payload into a single
//   registered output slot (valid/ready), pops the granted requester with a
//   one-cycle ack, and tells the arbiter when a grant was actually taken so
//   its priority only advances on real grants.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   req_i        per-requester pending flags (same vector as rr_top.req_i)
//   req_data_i   packed payloads, requester k at [k*PAYLOAD_W +: PAYLOAD_W]
//   req_num_i    selected index from rr_top.req_num_o
//   req_val_o    grant taken this cycle (combinational, to rr_top.req_val_i)
//   ack_o        one-hot pop to the granted requester (combinational)
//   out_valid_o  output slot holds a granted payload
//   out_data_o   granted payload
//   out_num_o    index of the requester that produced out_data_o
//   out_ready_i  downstream accepts the slot when out_valid_o is high
//   grant_cnt_o  saturating count of grants taken
//   err_o        sticky: arbiter selected a requester that is not pending
module rr_grant_stage #(
  parameter int DATAWIDTH = 3,
  parameter int PAYLOAD_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [(2**DATAWIDTH)-1:0]           req_i,
  input  logic [(2**DATAWIDTH)*PAYLOAD_W-1:0] req_data_i,
  input  logic [DATAWIDTH-1:0]                req_num_i,
  output logic                                req_val_o,
  output logic [(2**DATAWIDTH)-1:0]           ack_o,
  output logic                                out_valid_o,
  output logic [PAYLOAD_W-1:0]                out_data_o,
  output logic [DATAWIDTH-1:0]                out_num_o,
  input  logic                                out_ready_i,
  output logic [CNT_W-1:0]                    grant_cnt_o,
  output logic                                err_o
);

  localparam int N = 2**DATAWIDTH;

  logic                 slot_free;
  logic                 sel_ok;
  logic                 take;
  logic [PAYLOAD_W-1:0] sel_data;

  // The slot can accept a new grant when empty or when it drains this cycle,
  // which gives back-to-back grants with no bubble.
  always_comb begin
    slot_free = ~out_valid_o | out_ready_i;
    sel_ok    = req_i[req_num_i];
    take      = rst_n_i & slot_free & sel_ok;
    req_val_o = take;
    ack_o     = '0;
    if (take) begin
      ack_o[req_num_i] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (req_num_i == k[DATAWIDTH-1:0]) begin
        sel_data = req_data_i[k*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_num_o   <= '0;
      grant_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (take) begin
        out_valid_o <= 1'b1;
        out_data_o  <= sel_data;
        out_num_o   <= req_num_i;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end

      if (take && (grant_cnt_o != '1)) begin
        grant_cnt_o <= grant_cnt_o + 1'b1;
      end

      // Arbiter pointed at an idle requester while someone was pending.
      if ((|req_i) && !sel_ok) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_grant_stage.sv
module tb_rr_grant_stage;

  localparam int DW = 3;
  localparam int N  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*PW-1:0] req_data;
  logic [DW-1:0] req_num;
  logic          out_ready;

  logic          req_val, req_val2;
  logic [N-1:0]  ack, ack2;
  logic          out_valid, out_valid2;
  logic [PW-1:0] out_data, out_data2;
  logic [DW-1:0] out_num, out_num2;
  logic [15:0]   grant_cnt;
  logic [3:0]    grant_cnt4;
  logic          err, err2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_grant_stage #(.DATAWIDTH(DW), .PAYLOAD_W(PW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .req_data_i(req_data),
    .req_num_i(req_num), .req_val_o(req_val), .ack_o(ack),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_num_o(out_num),
    .out_ready_i(out_ready), .grant_cnt_o(grant_cnt), .err_o(err)
  );

  rr_grant_stage #(.DATAWIDTH(DW), .PAYLOAD_W(PW), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .req_data_i(req_data),
    .req_num_i(req_num), .req_val_o(req_val2), .ack_o(ack2),
    .out_valid_o(out_valid2), .out_data_o(out_data2), .out_num_o(out_num2),
    .out_ready_i(out_ready), .grant_cnt_o(grant_cnt4), .err_o(err2)
  );

  // ---------------- reference model ----------------
  logic [PW-1:0] pay [N];
  int  ptr = 0;          // rr_top priority pointer
  bit  m_init = 0;
  bit  m_valid = 0;
  int  m_data = 0, m_num = 0, m_cnt = 0, m_cnt4 = 0;
  bit  m_err = 0;
  bit  force_on = 0;
  int  force_val = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return p;
  endfunction

  function automatic bit exp_take();
    return rst_n === 1'b1 && (!m_valid || out_ready) && req[req_num];
  endfunction

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      m_init = 1; m_valid = 0; m_data = 0; m_num = 0;
      m_cnt = 0; m_cnt4 = 0; m_err = 0; ptr = 0;
    end else if (m_init) begin
      bit t;
      t = exp_take();
      if (t) begin
        m_valid = 1;
        m_data  = req_data[req_num*PW +: PW];
        m_num   = req_num;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
        ptr = (req_num + 1) % N;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (req != 0 && !req[req_num]) m_err = 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      bit t;
      t = exp_take();
      chk("req_val", req_val, t);
      chk("ack", ack, t ? (32'd1 << req_num) : 32'd0);
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_num", out_num, m_num);
      chk("grant_cnt", grant_cnt, m_cnt);
      chk("grant_cnt_sat", grant_cnt4, m_cnt4);
      chk("err", err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [N-1:0] r, input logic rdy, input logic rn);
    @(posedge clk);
    #1;
    rst_n     = rn;
    req       = r;
    out_ready = rdy;
    for (int k = 0; k < N; k++) req_data[k*PW +: PW] = pay[k];
    req_num   = force_on ? DW'(force_val) : DW'(rr_pick(r, ptr));
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; req_num = '0; out_ready = 1'b0;
    for (int k = 0; k < N; k++) pay[k] = PW'(8'hA0 + k);

    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      drive(8'h00, 1'b1, 1'b1);
      chk("idle_valid", out_valid, 0);
      chk("idle_req_val", req_val, 0);
      chk("idle_ack", ack, 0);
      chk("idle_cnt", grant_cnt, 0);
    end

    // two requesters, downstream always ready
    drive(8'h05, 1'b1, 1'b1);
    chk("t2_ack0", ack, 32'h01);
    drive(8'h04, 1'b1, 1'b1);
    chk("t2_ack2", ack, 32'h04);
    chk("t2_num0", out_num, 0);
    chk("t2_data0", out_data, 32'hA0);
    drive(8'h00, 1'b1, 1'b1);
    chk("t2_num2", out_num, 2);
    chk("t2_data2", out_data, 32'hA2);
    chk("t2_cnt", grant_cnt, 2);

    // backpressure with slot holding requester 3
    drive(8'h08, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(8'hFF, 1'b0, 1'b1);
      chk("bp_data", out_data, 32'hA3);
      chk("bp_num", out_num, 3);
      chk("bp_ack", ack, 0);
      chk("bp_req_val", req_val, 0);
    end
    drive(8'hFF, 1'b1, 1'b1);
    chk("bp_release_ack", ack, 32'h10);
    chk("bp_release_val", req_val, 1);
    drive(8'h00, 1'b1, 1'b1);
    chk("bp_next_num", out_num, 4);
    chk("bp_next_data", out_data, 32'hA4);
    chk("bp_cnt", grant_cnt, 4);

    // streaming from a fresh reset
    drive(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(8'hFF, 1'b1, 1'b1);
      chk("stream_ack", ack, 32'd1 << (i % 8));
      if (i > 0) chk("stream_num", out_num, (i - 1) % 8);
    end
    drive(8'h00, 1'b1, 1'b1);
    chk("stream_last", out_num, 7);
    chk("stream_cnt", grant_cnt, 16);
    chk("sat_cnt", grant_cnt4, 15);

    // arbiter misbehaviour
    force_on = 1; force_val = 2;
    drive(8'h10, 1'b1, 1'b1);
    chk("err_ack", ack, 0);
    chk("err_req_val", req_val, 0);
    chk("err_before", err, 0);
    force_on = 0;
    drive(8'h10, 1'b1, 1'b1);
    chk("err_set", err, 1);
    chk("err_grant_ack", ack, 32'h10);
    drive(8'h00, 1'b1, 1'b1);
    chk("err_sticky", err, 1);
    chk("err_grant_num", out_num, 4);

    // reset while slot is full
    drive(8'h01, 1'b1, 1'b1);
    drive(8'h01, 1'b1, 1'b0);
    chk("rst_ack", ack, 0);
    chk("rst_req_val", req_val, 0);
    chk("rst_pre_valid", out_valid, 1);
    drive(8'h00, 1'b0, 1'b1);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", grant_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) pay[k] = PW'($urandom);
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      force_on  = ($urandom_range(0, 31) == 0);
      force_val = $urandom_range(0, N - 1);
      drive(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
    end
    force_on = 0;
    drive(8'h00, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
